// File: rtl/booth_bist_ctrl_if.sv
// Operand/product bus between the BIST sequencer and the Booth multiplier.
// Combinational wiring only; the multiplier cannot stall the sequencer.
interface booth_bist_ctrl_if;
   logic [3:0] mul_x;
   logic [3:0] mul_y;
   logic       mul_rst;
   logic [7:0] mul_out;

   modport master (output mul_x, output mul_y, output mul_rst, input mul_out);
   modport slave  (input mul_x, input mul_y, input mul_rst, output mul_out);
endinterface

// File: rtl/booth_bist_ctrl.sv
// LFSR/MISR BIST sequencer for the 4x4 Booth multiplier; functional passthrough otherwise.
// Each pattern takes MUL_LAT+2 cycles, verdict one cycle after the last capture; no backpressure.
module booth_bist_ctrl #(
   parameter int          NUM_PATTERNS = 16,
   parameter int          MUL_LAT      = 4,
   parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               bist_mode,
   input  logic               start,
   input  logic [7:0]         golden_sig,
   input  logic [3:0]         func_x,
   input  logic [3:0]         func_y,
   input  logic               func_rst,
   booth_bist_ctrl_if.master  mul,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [7:0]         signature,
   output logic [7:0]         pat_cnt
);

   typedef enum logic [2:0] {IDLE, APPLY, RUN, CAPTURE, COMPARE, DONE} state_t;

   // An all-zero seed would lock the LFSR at zero forever.
   localparam logic [7:0] SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [3:0] RUN_LAST = 4'(MUL_LAT - 1);
   localparam logic [7:0] PAT_LAST = 8'(NUM_PATTERNS);

   state_t     state, state_nxt;
   logic [7:0] lfsr;
   logic [7:0] misr;
   logic [3:0] wait_cnt;
   logic       start_ok;
   logic       last_pat;
   logic       bist_own;

   function automatic logic [7:0] shift8(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   assign start_ok = bist_mode && start && ((state == IDLE) || (state == DONE));
   assign last_pat = (pat_cnt + 8'd1) == PAT_LAST;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start_ok) state_nxt = APPLY;
         APPLY:      state_nxt = RUN;
         RUN:        if (wait_cnt == RUN_LAST) state_nxt = CAPTURE;
         CAPTURE:    state_nxt = last_pat ? COMPARE : APPLY;
         COMPARE:    state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr     <= 8'h00;
         misr     <= 8'h00;
         pat_cnt  <= 8'h00;
         wait_cnt <= 4'h0;
         done     <= 1'b0;
         pass     <= 1'b0;
      end else begin
         if (start_ok) begin
            lfsr    <= SEED;
            misr    <= 8'h00;
            pat_cnt <= 8'h00;
            done    <= 1'b0;
            pass    <= 1'b0;
         end
         case (state)
            APPLY: wait_cnt <= 4'h0;
            RUN:   wait_cnt <= wait_cnt + 4'd1;
            CAPTURE: begin
               misr    <= shift8(misr) ^ mul.mul_out;
               lfsr    <= shift8(lfsr);
               pat_cnt <= pat_cnt + 8'd1;
            end
            COMPARE: begin
               pass <= (misr == golden_sig);
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state == APPLY) || (state == RUN) ||
                      (state == CAPTURE) || (state == COMPARE);
   assign signature = misr;

   // A run in flight keeps the multiplier even if bist_mode drops.
   assign bist_own    = bist_mode || busy;
   assign mul.mul_x   = bist_own ? lfsr[7:4] : func_x;
   assign mul.mul_y   = bist_own ? lfsr[3:0] : func_y;
   assign mul.mul_rst = bist_own ? ((state == IDLE) || (state == DONE) || (state == APPLY))
                                 : func_rst;

endmodule
